npu_cube_tree_input_pipe: RTL and testbench

Elastic, parametrised input stage feeding the NPU cube adder tree. Replaces the fixed one-register data/para capture with a PIPE_DEPTH-deep valid/ready pipeline, adds per-lane zero-gating, and adds a weight-stationary mode. In that mode a para vector is captured once and reused for a programmed number of data beats. Sits between the cube operand fetch logic and the MAC/adder-tree array.

---
 rtl/npu_cube_pkg.sv | 18 +
 rtl/npu_pipe_stage.sv | 42 ++++
 rtl/npu_cube_tree_input_pipe.sv | 133 +++++++++++++
 tb/tb_npu_cube_tree_input_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_cube_pkg.sv
// Shared definitions for the NPU cube input datapath.
//   - default lane count and element widths
//   - para reuse counter width default
//   - lane slice helper: bit offset of lane i inside a packed lane vector
package npu_cube_pkg;

    localparam int DEF_DWA         = 8;
    localparam int DEF_DWB         = 8;
    localparam int DEF_MAC_NUM     = 8;
    localparam int DEF_PIPE_DEPTH  = 2;
    localparam int DEF_REUSE_CNT_W = 8;

    // Lane i of a vector with element width w lives at [lane_lo(i, w) +: w].
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/npu_pipe_stage.sv
// Single valid/ready register slice.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears valid and payload)
//   i_valid/i_data  upstream beat
//   i_ready         downstream accepts the held beat this cycle
//   o_valid/o_data  held beat
// The upstream-facing ready (~o_valid | i_ready) is formed by the parent so the
// whole ready chain is flat logic rather than a ripple through instances.
module npu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic         i_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;
    logic         w_open;

    // Slot is free when empty or when its beat leaves in this same cycle.
    assign w_open = ~r_vld | i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (w_open) begin
            r_vld <= i_valid;
            // Payload holds its last value when the slot drains empty.
            if (i_valid) r_data <= i_data;
        end
    end

    assign o_valid = r_vld;
    assign o_data  = r_data;

endmodule

// File: rtl/npu_cube_tree_input_pipe.sv
// Elastic input stage for the NPU cube adder tree.
// PIPE_DEPTH-deep valid/ready pipeline carrying {last, para, data}, with
// per-lane zero gating and an optional weight-stationary mode in which a
// captured para vector is reused for cfg_reuse_num further beats.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake
//   in_data/in_para            lane-packed operand vectors
//   in_lane_en                 per-lane enable (0 zeroes data and para)
//   in_last                    end of operand block, ends para reuse
//   cfg_para_hold              weight-stationary enable
//   cfg_reuse_num              extra beats reusing a captured para
//   out_valid/out_ready        output handshake
//   add_tree_data/para, out_last   beat to the adder tree
//   busy                       any beat in flight or reuse pending
module npu_cube_tree_input_pipe
    import npu_cube_pkg::*;
#(
    parameter int DWA              = DEF_DWA,
    parameter int DWB              = DEF_DWB,
    parameter int NPU_CUBE_MAC_NUM = DEF_MAC_NUM,
    parameter int PIPE_DEPTH       = DEF_PIPE_DEPTH,
    parameter int REUSE_CNT_W      = DEF_REUSE_CNT_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DWA*NPU_CUBE_MAC_NUM-1:0] in_data,
    input  logic [DWB*NPU_CUBE_MAC_NUM-1:0] in_para,
    input  logic [NPU_CUBE_MAC_NUM-1:0]     in_lane_en,
    input  logic                            in_last,
    input  logic                            cfg_para_hold,
    input  logic [REUSE_CNT_W-1:0]          cfg_reuse_num,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DWA*NPU_CUBE_MAC_NUM-1:0] add_tree_data,
    output logic [DWB*NPU_CUBE_MAC_NUM-1:0] add_tree_para,
    output logic                            out_last,
    output logic                            busy
);

    localparam int DW = DWA * NPU_CUBE_MAC_NUM;
    localparam int PB = DWB * NPU_CUBE_MAC_NUM;
    localparam int PW = DW + PB + 1;
    localparam logic [REUSE_CNT_W-1:0] CNT_ONE = REUSE_CNT_W'(1);

    // Index k: input side of stage k; index PIPE_DEPTH: output of last stage.
    logic [PIPE_DEPTH:0]         w_vld;
    logic [PIPE_DEPTH:0]         w_rdy;
    logic [PIPE_DEPTH:0][PW-1:0] w_pay;

    logic [DW-1:0]          w_data_g;
    logic [PB-1:0]          w_para_sel;
    logic [PB-1:0]          w_para_g;
    logic [PB-1:0]          r_hold;
    logic [PB-1:0]          w_hold_nxt;
    logic [REUSE_CNT_W-1:0] r_cnt;
    logic [REUSE_CNT_W-1:0] w_cnt_nxt;
    logic                   w_acc;

    // ---------------- para reuse ----------------
    assign w_acc = in_valid & in_ready;

    always_comb begin
        w_para_sel = in_para;
        w_hold_nxt = r_hold;
        w_cnt_nxt  = r_cnt;
        // A nonzero count only exists in hold mode; dropping hold mid-block
        // switches straight back to the live para.
        if (cfg_para_hold && (r_cnt != '0)) w_para_sel = r_hold;
        if (w_acc) begin
            if (!cfg_para_hold) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == '0) begin
                // Capture point: cfg_reuse_num is only sampled here.
                w_hold_nxt = in_para;
                w_cnt_nxt  = cfg_reuse_num;
            end else begin
                w_cnt_nxt = r_cnt - CNT_ONE;
            end
            // Block end forces the next block to recapture.
            if (in_last) w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_cnt  <= '0;
        end else begin
            r_hold <= w_hold_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // ---------------- lane gating ----------------
    // Held para is stored ungated; gating follows each beat's own lane enables.
    for (genvar l = 0; l < NPU_CUBE_MAC_NUM; l++) begin : g_lane
        assign w_data_g[lane_lo(l, DWA) +: DWA] = in_lane_en[l] ? in_data[lane_lo(l, DWA) +: DWA]    : '0;
        assign w_para_g[lane_lo(l, DWB) +: DWB] = in_lane_en[l] ? w_para_sel[lane_lo(l, DWB) +: DWB] : '0;
    end

    // ---------------- pipeline ----------------
    assign w_vld[0]          = in_valid;
    assign w_pay[0]          = {in_last, w_para_g, w_data_g};
    assign w_rdy[PIPE_DEPTH] = out_ready;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
        // Stage g can take a beat unless it and every stage after it are full
        // and the output is stalled. Written from valids directly so the
        // ready path has no chain through w_rdy itself.
        assign w_rdy[g] = out_ready | ~(&w_vld[PIPE_DEPTH:g+1]);

        npu_pipe_stage #(.W(PW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_vld[g]),
            .i_ready (w_rdy[g+1]),
            .i_data  (w_pay[g]),
            .o_valid (w_vld[g+1]),
            .o_data  (w_pay[g+1])
        );
    end

    assign in_ready      = w_rdy[0];
    assign out_valid     = w_vld[PIPE_DEPTH];
    assign add_tree_data = w_pay[PIPE_DEPTH][DW-1:0];
    assign add_tree_para = w_pay[PIPE_DEPTH][DW +: PB];
    assign out_last      = w_pay[PIPE_DEPTH][PW-1];
    assign busy          = (|w_vld[PIPE_DEPTH:1]) | (r_cnt != '0);

endmodule

// File: tb/tb_npu_cube_tree_input_pipe.sv
module tb_npu_cube_tree_input_pipe;

    localparam int N  = 8;
    localparam int DWA = 8;
    localparam int DWB = 8;
    localparam int D  = 2;
    localparam int RW = 8;
    localparam int VW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_data = '0;
    logic [VW-1:0] in_para = '0;
    logic [N-1:0]  in_lane_en = '1;
    logic          in_last = 1'b0;
    logic          cfg_para_hold = 1'b0;
    logic [RW-1:0] cfg_reuse_num = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] add_tree_data;
    logic [VW-1:0] add_tree_para;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    npu_cube_tree_input_pipe #(
        .DWA(DWA), .DWB(DWB), .NPU_CUBE_MAC_NUM(N), .PIPE_DEPTH(D), .REUSE_CNT_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_para(in_para), .in_lane_en(in_lane_en), .in_last(in_last),
        .cfg_para_hold(cfg_para_hold), .cfg_reuse_num(cfg_reuse_num),
        .out_valid(out_valid), .out_ready(out_ready),
        .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
        .out_last(out_last), .busy(busy)
    );

    typedef struct packed {
        logic [VW-1:0] d;
        logic [VW-1:0] p;
        logic          l;
    } exp_t;

    exp_t          sb[$];
    int            n_run = 0;
    int            n_fail = 0;
    logic [VW-1:0] m_hold = '0;
    int            m_cnt = 0;

    function automatic logic [VW-1:0] gate(input logic [VW-1:0] v, input logic [N-1:0] en);
        logic [VW-1:0] r;
        r = v;
        for (int k = 0; k < N; k++) if (!en[k]) r[k*8 +: 8] = '0;
        return r;
    endfunction

    // Reference behaviour of one accepted beat.
    function automatic exp_t model_step();
        exp_t          r;
        logic [VW-1:0] p;
        if (!cfg_para_hold) begin
            p = in_para; m_cnt = 0;
        end else if (m_cnt == 0) begin
            m_hold = in_para; p = in_para; m_cnt = int'(cfg_reuse_num);
        end else begin
            p = m_hold; m_cnt = m_cnt - 1;
        end
        if (in_last) m_cnt = 0;
        r.d = gate(in_data, in_lane_en);
        r.p = gate(p, in_lane_en);
        r.l = in_last;
        return r;
    endfunction

    // One cycle: called at a falling edge with inputs already driven.
    task automatic tick(input exp_t e, input bit dir, output bit acc, output bit fire,
                        output bit ov, output exp_t obs);
        exp_t m;
        #1;
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        ov   = out_valid;
        obs  = {add_tree_data, add_tree_para, out_last};
        if (acc) begin
            m = model_step();
            sb.push_back(dir ? e : m);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_lane_en = '1;
        cfg_para_hold = 1'b0; cfg_reuse_num = '0; out_ready = 1'b1;
        sb.delete(); m_hold = '0; m_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_run++; if (add_tree_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", add_tree_data); end
        n_run++; if (add_tree_para !== '0) begin n_fail++; $display("FAIL reset_para got %h exp 0", add_tree_para); end
        n_run++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", out_last); end
        @(negedge clk);
    endtask

    task automatic test_latency();
        exp_t e, obs, x;
        bit acc, fire, ov;
        int acc_cyc;
        logic [VW-1:0] d, p;
        acc_cyc = -1;
        for (int k = 0; k < N; k++) begin d[k*8 +: 8] = 8'(k + 1); p[k*8 +: 8] = 8'(8'h11 + k); end
        e = {d, p, 1'b0};
        for (int c = 0; c < 6; c++) begin
            in_valid = (acc_cyc < 0); in_data = d; in_para = p; in_lane_en = '1;
            out_ready = 1'b1; cfg_para_hold = 1'b0; in_last = 1'b0;
            tick(e, 1'b1, acc, fire, ov, obs);
            if (acc_cyc >= 0) begin
                n_run++;
                if (ov !== (c - acc_cyc == D)) begin
                    n_fail++; $display("FAIL latency_valid cyc+%0d got %b exp %b", c - acc_cyc, ov, (c - acc_cyc == D));
                end
                if (c - acc_cyc == 1) begin
                    n_run++;
                    if (obs !== '0) begin n_fail++; $display("FAIL latency_pre_out got %h exp 0", obs); end
                end
            end
            if (acc && acc_cyc < 0) acc_cyc = c;
            if (fire) begin
                n_run++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL latency_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL latency_beat got %h exp %h", obs, x); end end
            end
        end
        n_run++; if (acc_cyc !== 0) begin n_fail++; $display("FAIL latency_accept got cyc %0d exp 0", acc_cyc); end
    endtask

    task automatic test_backpressure();
        exp_t e, obs, x, prev_obs;
        bit acc, fire, ov, prev_stall, saw_full;
        int i, pops;
        i = 0; pops = 0; prev_stall = 0; saw_full = 0; prev_obs = '0;
        for (int c = 0; c < 40 && pops < 10; c++) begin
            in_valid = (i < 10); in_data = {8{8'(i)}}; in_para = ~{8{8'(i)}};
            in_lane_en = '1; in_last = 1'b0; cfg_para_hold = 1'b0;
            out_ready = !(c >= 3 && c <= 7);
            e = {in_data, in_para, 1'b0};
            tick(e, 1'b1, acc, fire, ov, obs);
            if (prev_stall) begin
                n_run++;
                if (!ov || obs !== prev_obs) begin n_fail++; $display("FAIL bp_stable got %b/%h exp 1/%h", ov, obs, prev_obs); end
            end
            if (in_valid && !acc) begin
                saw_full = 1;
                n_run++;
                if (i - pops != D) begin n_fail++; $display("FAIL bp_buffered got %0d exp %0d", i - pops, D); end
            end
            if (acc) i++;
            if (fire) begin
                n_run++; pops++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL bp_order got %h exp %h", obs, x); end end
            end
            prev_stall = ov && !out_ready; prev_obs = obs;
        end
        n_run++; if (!saw_full) begin n_fail++; $display("FAIL bp_in_ready_drop got 0 exp 1"); end
        n_run++; if (pops != 10 || sb.size() != 0) begin n_fail++; $display("FAIL bp_count got %0d left %0d exp 10 left 0", pops, sb.size()); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_gating();
        exp_t e, obs, x;
        bit acc, fire, ov;
        int i, pops;
        i = 0; pops = 0;
        e = {64'hFF00_FF00_00FF_00FF, 64'h7F00_7F00_007F_007F, 1'b0};
        for (int c = 0; c < 10 && pops < 1; c++) begin
            in_valid = (i < 1); in_data = '1; in_para = {8{8'h7F}}; in_lane_en = 8'b1010_0101;
            in_last = 1'b0; cfg_para_hold = 1'b0; out_ready = 1'b1;
            tick(e, 1'b1, acc, fire, ov, obs);
            if (acc) i++;
            if (fire) begin
                n_run++; pops++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL gate_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL gate_lanes got %h exp %h", obs, x); end end
            end
        end
        n_run++; if (pops != 1) begin n_fail++; $display("FAIL gate_count got %0d exp 1", pops); end
        in_valid = 1'b0; in_lane_en = '1;
    endtask

    task automatic test_weight_stationary();
        exp_t e, obs, x;
        bit acc, fire, ov;
        int i, pops;
        byte pexp [8] = '{0, 0, 0, 0, 4, 4, 4, 4};
        do_reset();
        i = 0; pops = 0;
        for (int c = 0; c < 30 && pops < 8; c++) begin
            in_valid = (i < 8); in_data = {8{8'(i)}}; in_para = {8{8'(i)}}; in_lane_en = '1;
            in_last = 1'b0; cfg_para_hold = 1'b1; cfg_reuse_num = 8'd3; out_ready = 1'b1;
            e = {in_data, {8{pexp[i % 8]}}, 1'b0};
            tick(e, 1'b1, acc, fire, ov, obs);
            if (acc) i++;
            if (fire) begin
                n_run++; pops++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL ws_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL ws_para got %h exp %h", obs, x); end end
            end
        end
        n_run++; if (pops != 8) begin n_fail++; $display("FAIL ws_count got %0d exp 8", pops); end
        in_valid = 1'b0;
    endtask

    task automatic test_last_early();
        exp_t e, obs, x;
        bit acc, fire, ov;
        int i, pops;
        byte pexp [6] = '{0, 0, 2, 2, 2, 2};
        do_reset();
        i = 0; pops = 0;
        for (int c = 0; c < 30 && pops < 6; c++) begin
            in_valid = (i < 6); in_data = {8{8'(i)}}; in_para = {8{8'(i)}}; in_lane_en = '1;
            in_last = (i == 1); cfg_para_hold = 1'b1; cfg_reuse_num = 8'd3; out_ready = 1'b1;
            e = {in_data, {8{pexp[i % 6]}}, (i == 1)};
            tick(e, 1'b1, acc, fire, ov, obs);
            if (acc) i++;
            if (fire) begin
                n_run++; pops++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL last_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL last_beat got %h exp %h", obs, x); end end
            end
        end
        n_run++; if (pops != 6) begin n_fail++; $display("FAIL last_count got %0d exp 6", pops); end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset_midstream();
        exp_t e, obs, x;
        bit acc, fire, ov;
        int i, pops;
        do_reset();
        i = 0;
        for (int c = 0; c < 10 && i < 2; c++) begin
            in_valid = 1'b1; in_data = {8{8'(8'hA0 + i)}}; in_para = {8{8'(8'h05 + i)}};
            cfg_para_hold = 1'b1; cfg_reuse_num = 8'd3; out_ready = 1'b0;
            tick(e, 1'b0, acc, fire, ov, obs);
            if (acc) i++;
        end
        in_valid = 1'b0;
        #1;
        n_run++; if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_prefill got busy=%b ov=%b ir=%b exp 1/1/0", busy, out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        n_run++; if (add_tree_data !== '0 || add_tree_para !== '0) begin
            n_fail++; $display("FAIL mid_rst_out got %h/%h exp 0/0", add_tree_data, add_tree_para);
        end
        sb.delete(); m_hold = '0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i = 0; pops = 0;
        for (int c = 0; c < 10 && pops < 1; c++) begin
            in_valid = (i < 1); in_data = {8{8'h3C}}; in_para = {8{8'h09}};
            cfg_para_hold = 1'b1; cfg_reuse_num = 8'd3; out_ready = 1'b1;
            e = {{8{8'h3C}}, {8{8'h09}}, 1'b0};
            tick(e, 1'b1, acc, fire, ov, obs);
            if (acc) i++;
            if (fire) begin
                n_run++; pops++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL mid_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL mid_recapture got %h exp %h", obs, x); end end
            end
        end
        n_run++; if (pops != 1) begin n_fail++; $display("FAIL mid_count got %0d exp 1", pops); end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t e, obs, x;
        bit acc, fire, ov;
        do_reset();
        e = '0;
        for (int c = 0; c < 420; c++) begin
            if (c < 400) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data = {$urandom, $urandom}; in_para = {$urandom, $urandom};
                in_lane_en = 8'($urandom); in_last = ($urandom_range(0, 5) == 0);
                cfg_para_hold = ($urandom_range(0, 4) != 0); cfg_reuse_num = 8'($urandom_range(0, 3));
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            tick(e, 1'b0, acc, fire, ov, obs);
            if (fire) begin
                n_run++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rand_sb got extra beat %h exp none", obs); end
                else begin x = sb.pop_front(); if (obs !== x) begin n_fail++; $display("FAIL rand_beat cyc %0d got %h exp %h", c, obs, x); end end
            end
        end
        n_run++; if (sb.size() != 0) begin n_fail++; $display("FAIL rand_drain got %0d left exp 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_gating();
        test_weight_stationary();
        test_last_early();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
